mem_dp_sync: RTL and testbench
==============================

Name: mem_dp_sync

Overview:
Parametrised simple-dual-port synchronous memory for the memory-to-memory transfer datapath; successor to the fixed 8x8 single-port source/destination memories. Independent write and read ports in one cycle, byte-lane write enables, selectable read latency and read-during-write policy. Built-in init sequencer fills every word with INIT_VALUE after reset or on request, and flags busy while doing so.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.
READ_LAT, 1, read latency in cycles; legal values are 1 or 2 (2 adds an output register).
RDW_MODE, 0, same-address read-during-write policy; 0 = old data, 1 = new (merged) data.
INIT_VALUE, 0, DATA_W-bit value written to every word by the init sequencer.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous active-low reset.
init_req  input  1  one-cycle pulse that restarts the init sequence.
init_busy  output  1  high while the init sequence runs.
wr_en  input  1  write strobe.
wr_addr  input  ADDR_W  write address.
wr_data  input  DATA_W  write data.
wr_be  input  DATA_W/8  byte-lane enables; bit i enables bits [8i+7:8i].
rd_en  input  1  read strobe.
rd_addr  input  ADDR_W  read address.
rd_data  output  DATA_W  read data; holds its last value between reads.
rd_valid  output  1  one-cycle pulse that qualifies rd_data.

Behaviour:
- Reset (resetn low, asynchronous): rd_data=0, rd_valid=0, pipeline valid bits=0, FSM=INIT, init address counter=0, init_busy=1. The array itself is not reset; the init sequence overwrites it.
- FSM states and transitions:
  - INIT: each cycle writes INIT_VALUE (all lanes) to init_addr, then increments it. On the cycle that writes DEPTH-1, init_busy stays 1; READY is entered on the next edge, where init_busy=0.
  - READY: normal operation. init_req=1 returns the FSM to INIT with init_addr=0, and init_busy is 1 from the next cycle.
  - init_req while already in INIT: restarts the sequence at address 0.
- During INIT, wr_en and rd_en are ignored: no array update, and no rd_valid is generated. Any read already in the READ_LAT=2 pipeline still completes.
- Init duration: DEPTH cycles of init_busy=1 after reset release; DEPTH cycles after the init_req edge.
- Write in READY: when wr_en=1, each lane with wr_be[i]=1 is updated at the edge. wr_be=0 is a legal no-op.
- Read in READY, rd_en=1 sampled at edge N:
  - READ_LAT=1: rd_data and rd_valid=1 appear after edge N.
  - READ_LAT=2: rd_data and rd_valid=1 appear after edge N+1.
- rd_valid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back valids (full throughput). rd_data is unchanged when no read completes.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the word with the enabled lanes replaced by wr_data and the other lanes old.
  - Different addresses never interact.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range access exists. The init counter stops at DEPTH-1 and does not wrap.
- Reset asserted mid-init or mid-read: outputs clear immediately, any pending read is dropped, and a full init runs after release.

Test Plan:
- Reset release, default params -> init_busy=1 for 8 cycles then 0. Reads of addresses 0..7 each return 0x00 with rd_valid one cycle after rd_en.
- Write 0xA5 to address 3, then read address 3 with READ_LAT=2 -> rd_data=0xA5 and rd_valid=1 two edges after rd_en. No valid otherwise.
- DATA_W=16: write 0x1234 to address 5, then write 0xABCD with wr_be=2'b01 -> read returns 0x12CD.
- Same-cycle write 0x77 and read at address 2, which holds 0x11 -> RDW_MODE=0 gives 0x11, RDW_MODE=1 gives 0x77.
- Fill addresses with 0xFF, pulse init_req, and assert wr_en/rd_en during busy -> init_busy high 8 cycles, no rd_valid, and all words read back INIT_VALUE afterwards.
- Assert resetn low at init cycle 4 and during a READ_LAT=2 read in flight -> rd_valid and rd_data go 0 immediately. After release the full 8-cycle init runs again.

Source files
------------

// File: rtl/mem_dp_sync.sv
// Simple-dual-port synchronous memory with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write policy and a self-starting init sequencer.
module mem_dp_sync #(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 3,
   parameter int                READ_LAT   = 1,
   parameter int                RDW_MODE   = 0,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  init_req,
   output logic                  init_busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int LANES = DATA_W/8;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] init_addr_q, init_addr_d;
   logic              wr_acc;
   logic              vld_p0;
   logic [DATA_W-1:0] rd_word_p0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              vld_out;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [LANES-1:0]  be);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   // The init counter parks at DEPTH-1; only init_req rewinds it.
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      if (state_q == ST_INIT) begin
         if (init_req) begin
            init_addr_d = '0;
         end else if (&init_addr_q) begin
            state_d = ST_READY;
         end else begin
            init_addr_d = init_addr_q + ADDR_W'(1);
         end
      end else if (init_req) begin
         state_d     = ST_INIT;
         init_addr_d = '0;
      end
   end

   // Stage p0: array access, write merge and read-during-write bypass
   always_comb begin
      wr_acc     = wr_en && (state_q == ST_READY);
      vld_p0     = rd_en && (state_q == ST_READY);
      mem_we     = (state_q == ST_INIT) || wr_acc;
      mem_waddr  = (state_q == ST_INIT) ? init_addr_q : wr_addr;
      mem_wdata  = (state_q == ST_INIT) ? INIT_VALUE
                                        : merge_lanes(mem_q[wr_addr], wr_data, wr_be);
      rd_word_p0 = mem_q[rd_addr];
      if ((RDW_MODE == 1) && wr_acc && (wr_addr == rd_addr)) rd_word_p0 = mem_wdata;
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   // Stage p1: optional extra register for the two-cycle read path
   if (READ_LAT == 2) begin : g_lat2
      logic              vld_p1_q;
      logic [DATA_W-1:0] rd_data_p1_q;

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) vld_p1_q <= 1'b0;
         else         vld_p1_q <= vld_p0;
      end

      always_ff @(posedge clock) begin
         if (vld_p0) rd_data_p1_q <= rd_word_p0;
      end

      assign vld_out  = vld_p1_q;
      assign data_out = rd_data_p1_q;
   end else begin : g_lat1
      assign vld_out  = vld_p0;
      assign data_out = rd_word_p0;
   end

   // Output stage: rd_data holds between completions
   always_comb begin
      rd_valid_d = vld_out;
      rd_data_d  = vld_out ? data_out : rd_data_q;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign init_busy = (state_q == ST_INIT);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_dp_sync.sv
// Bench for mem_dp_sync: two instances (8-bit/latency 1/old-data and 16-bit/latency 2/new-data)
// driven in lockstep and compared every cycle against a word-array reference model.
module tb_mem_dp_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   bit          s_ir [2];
   bit          s_we [2];
   logic [2:0]  s_wa [2];
   logic [15:0] s_wd [2];
   logic [1:0]  s_be [2];
   bit          s_re [2];
   logic [2:0]  s_ra [2];

   logic        busy_a, vld_a, busy_b, vld_b;
   logic [7:0]  rdd_a;
   logic [15:0] rdd_b;

   mem_dp_sync #(.DATA_W(8), .ADDR_W(3), .READ_LAT(1), .RDW_MODE(0), .INIT_VALUE(8'h00)) u_a (
      .clock(clk), .resetn(resetn), .init_req(s_ir[0]), .init_busy(busy_a),
      .wr_en(s_we[0]), .wr_addr(s_wa[0]), .wr_data(s_wd[0][7:0]), .wr_be(s_be[0][0]),
      .rd_en(s_re[0]), .rd_addr(s_ra[0]), .rd_data(rdd_a), .rd_valid(vld_a));

   mem_dp_sync #(.DATA_W(16), .ADDR_W(3), .READ_LAT(2), .RDW_MODE(1), .INIT_VALUE(16'h5A3C)) u_b (
      .clock(clk), .resetn(resetn), .init_req(s_ir[1]), .init_busy(busy_b),
      .wr_en(s_we[1]), .wr_addr(s_wa[1]), .wr_data(s_wd[1]), .wr_be(s_be[1]),
      .rd_en(s_re[1]), .rd_addr(s_ra[1]), .rd_data(rdd_b), .rd_valid(vld_b));

   int          LAT [2] = '{1, 2};
   int          RDW [2] = '{0, 1};
   logic [15:0] IV  [2] = '{16'h0000, 16'h5A3C};
   logic [15:0] MSK [2] = '{16'h00FF, 16'hFFFF};

   logic [15:0] mm [2][8];
   int          busy_left [2];
   logic [15:0] exp_d [2];
   bit          exp_v [2];
   bit          pend_v [2];
   logic [15:0] pend_d [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mrg(input logic [15:0] old_w, input logic [15:0] nw,
                                       input logic [1:0] be, input logic [15:0] msk);
      logic [15:0] r;
      r = old_w;
      if (be[0]) r[7:0]  = nw[7:0];
      if (be[1]) r[15:8] = nw[15:8];
      return r & msk;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         exp_d[i] = '0; exp_v[i] = 1'b0; pend_v[i] = 1'b0; busy_left[i] = 8;
      end
   endtask

   task automatic model_edge();
      bit          acc;
      logic [15:0] rv, wv;
      if (!resetn) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         acc = 1'b0;
         rv  = '0;
         if (busy_left[i] > 0) begin
            mm[i][8 - busy_left[i]] = IV[i];
            busy_left[i]--;
         end else begin
            acc = s_re[i];
            rv  = mm[i][s_ra[i]];
            wv  = mrg(mm[i][s_wa[i]], s_wd[i], s_be[i], MSK[i]);
            if (RDW[i] == 1 && s_we[i] && s_wa[i] == s_ra[i]) rv = wv;
            if (s_we[i]) mm[i][s_wa[i]] = wv;
         end
         if (s_ir[i]) busy_left[i] = 8;
         if (LAT[i] == 1) begin
            exp_v[i] = acc;
            if (acc) exp_d[i] = rv;
         end else begin
            exp_v[i] = pend_v[i];
            if (pend_v[i]) exp_d[i] = pend_d[i];
            pend_v[i] = acc;
            pend_d[i] = rv;
         end
      end
   endtask

   task automatic check_all();
      chk($sformatf("a_busy@%0d", cyc), {15'b0, busy_a}, {15'b0, busy_left[0] > 0});
      chk($sformatf("a_valid@%0d", cyc), {15'b0, vld_a}, {15'b0, exp_v[0]});
      chk($sformatf("a_data@%0d", cyc), {8'h00, rdd_a}, exp_d[0]);
      chk($sformatf("b_busy@%0d", cyc), {15'b0, busy_b}, {15'b0, busy_left[1] > 0});
      chk($sformatf("b_valid@%0d", cyc), {15'b0, vld_b}, {15'b0, exp_v[1]});
      chk($sformatf("b_data@%0d", cyc), rdd_b, exp_d[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle();
      for (int i = 0; i < 2; i++) begin
         s_ir[i] = 0; s_we[i] = 0; s_wa[i] = '0; s_wd[i] = '0;
         s_be[i] = '0; s_re[i] = 0; s_ra[i] = '0;
      end
   endtask

   task automatic set_wr(input int i, input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      s_we[i] = 1; s_wa[i] = a; s_wd[i] = d; s_be[i] = be;
   endtask

   task automatic set_rd(input int i, input logic [2:0] a);
      s_re[i] = 1; s_ra[i] = a;
   endtask

   task automatic async_reset();
      #2 resetn = 1'b0;
      #1 model_reset();
      check_all();
      idle();
      repeat (2) tick();
      @(negedge clk) resetn = 1'b1;
   endtask

   initial begin
      idle();
      resetn = 1'b0;
      model_reset();
      #3 check_all();
      repeat (2) tick();
      @(negedge clk) resetn = 1'b1;
      repeat (9) tick();

      // every word reads back its init value
      for (int k = 0; k < 8; k++) begin
         idle(); set_rd(0, 3'(k)); set_rd(1, 3'(k)); tick();
      end
      idle(); repeat (2) tick();

      // single word write then read
      set_wr(0, 3'd3, 16'h00A5, 2'b11); set_wr(1, 3'd3, 16'h00A5, 2'b11); tick();
      idle(); set_rd(0, 3'd3); set_rd(1, 3'd3); tick();
      idle(); repeat (2) tick();

      // partial byte-lane write
      set_wr(0, 3'd5, 16'h0034, 2'b01); set_wr(1, 3'd5, 16'h1234, 2'b11); tick();
      idle(); set_wr(0, 3'd5, 16'h00CD, 2'b00); set_wr(1, 3'd5, 16'hABCD, 2'b01); tick();
      idle(); set_rd(0, 3'd5); set_rd(1, 3'd5); tick();
      idle(); repeat (2) tick();

      // same-address read during write
      set_wr(0, 3'd2, 16'h0011, 2'b11); set_wr(1, 3'd2, 16'h1111, 2'b11); tick();
      idle();
      set_wr(0, 3'd2, 16'h0077, 2'b01); set_rd(0, 3'd2);
      set_wr(1, 3'd2, 16'h7777, 2'b01); set_rd(1, 3'd2); tick();
      idle(); set_wr(1, 3'd2, 16'h9999, 2'b11); set_rd(1, 3'd2); set_rd(0, 3'd2); tick();
      idle(); set_rd(1, 3'd2); tick();
      idle(); repeat (2) tick();

      // randomized traffic with occasional re-init
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            s_we[i] = ($urandom % 2) == 0;
            s_wa[i] = 3'($urandom % 8);
            s_wd[i] = 16'($urandom);
            s_be[i] = 2'($urandom % 4);
            s_re[i] = ($urandom % 3) != 0;
            s_ra[i] = (($urandom % 4) == 0) ? s_wa[i] : 3'($urandom % 8);
            s_ir[i] = ($urandom % 50) == 0;
         end
         tick();
      end
      idle(); repeat (10) tick();

      // fill, re-init with traffic during busy, read back
      for (int k = 0; k < 8; k++) begin
         idle(); set_wr(0, 3'(k), 16'hFFFF, 2'b11); set_wr(1, 3'(k), 16'hFFFF, 2'b11); tick();
      end
      idle(); s_ir[0] = 1; s_ir[1] = 1; tick();
      for (int k = 0; k < 8; k++) begin
         idle();
         set_wr(0, 3'(k), 16'h00EE, 2'b11); set_wr(1, 3'(k), 16'hEEEE, 2'b11);
         set_rd(0, 3'(k)); set_rd(1, 3'(k)); tick();
      end
      for (int k = 0; k < 8; k++) begin
         idle(); set_rd(0, 3'(k)); set_rd(1, 3'(k)); tick();
      end
      idle(); repeat (2) tick();

      // reset in the middle of an init sequence
      s_ir[0] = 1; s_ir[1] = 1; tick();
      idle(); repeat (3) tick();
      async_reset();
      repeat (9) tick();

      // reset with a two-cycle read in flight and non-zero rd_data
      set_wr(0, 3'd4, 16'h00C3, 2'b11); set_wr(1, 3'd4, 16'hBEEF, 2'b11); tick();
      idle(); set_rd(0, 3'd4); set_rd(1, 3'd4); tick();
      idle(); repeat (2) tick();
      set_rd(0, 3'd4); set_rd(1, 3'd4); tick();
      idle();
      async_reset();
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
